seg7_scan_ctrl: RTL

// Time-multiplexed scan controller for the 7-segment display peripheral. Takes per-digit hex

---
 rtl/seg7_scan_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: blank gap before every digit slot,
// shadowed digit/dp/enable registers refreshed only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned ON_CYCLES      = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          enable,
    input  logic [4*NUM_DIGITS-1:0]       digit_data,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          cfg_load,
    output logic                          cfg_pending,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
    output logic                          frame_tick
);

    localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
    localparam int unsigned MaxCyc = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] OnLast    = CntW'(ON_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    tick_q, tick_d;

    logic                    frame_start;
    logic [NUM_DIGITS-1:0]   an_on;
    logic [6:0]              seg_on;
    logic                    dp_on;
    logic [4*NUM_DIGITS-1:0] data_shift;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        sh_data_d   = sh_data_q;
        sh_dp_d     = sh_dp_q;
        sh_en_d     = sh_en_q;
        frame_start = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d     = StBlank;
                    cnt_d       = '0;
                    idx_d       = '0;
                    frame_start = 1'b1;
                end
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StShow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StShow: begin
                    if (cnt_q == OnLast) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        if (idx_q == IdxLast) begin
                            idx_d       = '0;
                            frame_start = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // A load coinciding with frame start is taken at once and never shows as pending.
        if (frame_start) begin
            if (pending_q || cfg_load) begin
                sh_data_d = digit_data;
                sh_dp_d   = dp_in;
                sh_en_d   = digit_en;
            end
            pending_d = 1'b0;
        end else if (cfg_load) begin
            pending_d = 1'b1;
        end
    end

    // Outputs are derived from next-state so the registered pins line up with the state.
    always_comb begin
        an_on      = '0;
        seg_on     = '0;
        dp_on      = 1'b0;
        data_shift = sh_data_d >> {idx_d, 2'b00};
        if (state_d == StShow) begin
            an_on  = sh_en_d[idx_d] ? ({{(NUM_DIGITS - 1){1'b0}}, 1'b1} << idx_d) : '0;
            seg_on = hex7(data_shift[3:0]);
            dp_on  = sh_dp_d[idx_d];
        end
        an_d   = {NUM_DIGITS{AN_ACTIVE_LOW}} ^ an_on;
        seg_d  = {7{SEG_ACTIVE_LOW}} ^ seg_on;
        dp_d   = SEG_ACTIVE_LOW ^ dp_on;
        tick_d = frame_start;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            sh_data_q <= '0;
            sh_dp_q   <= '0;
            sh_en_q   <= '0;
            an_q      <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            seg_q     <= {7{SEG_ACTIVE_LOW}};
            dp_q      <= SEG_ACTIVE_LOW;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            sh_data_q <= sh_data_d;
            sh_dp_q   <= sh_dp_d;
            sh_en_q   <= sh_en_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            tick_q    <= tick_d;
        end
    end

    assign cfg_pending = pending_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign scan_idx    = idx_q;
    assign frame_tick  = tick_q;

endmodule
